// File: rtl/reg_bus_arbiter_if.sv
// rtl/reg_bus_arbiter_if.sv - requester-side command/read-return port of the register bus arbiter
//
// One instance per requester. The requester uses the master modport, the
// arbiter uses the slave modport.
//   valid  : command valid (requester)
//   wr     : 1 = write, 0 = read (requester)
//   addr   : register address (requester)
//   wdata  : write data (requester)
//   ready  : command accepted this cycle (arbiter)
//   rvalid : read data valid, 1-cycle pulse (arbiter)
//   rdata  : read data, holds when rvalid is low (arbiter)
//   err    : write rejected, 1-cycle pulse (arbiter)

interface reg_bus_arbiter_if;
    logic       valid;
    logic       wr;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic       ready;
    logic       rvalid;
    logic [7:0] rdata;
    logic       err;

    modport master (
        output valid, wr, addr, wdata,
        input  ready, rvalid, rdata, err
    );

    modport slave (
        input  valid, wr, addr, wdata,
        output ready, rvalid, rdata, err
    );
endinterface

// File: rtl/reg_bus_arbiter.sv
// rtl/reg_bus_arbiter.sv - round-robin sharing of the register-block access port between two requesters
//
// Port 0 is the host bridge, port 1 the on-chip configuration sequencer.
// A fired command is issued on the register bus one cycle later from
// registers; read data is sampled at the end of the issue cycle and returned
// one cycle after that to the port that owned the command.
//
// Optional feature macro: REG_ARB_WR_PROTECT_EN
//   When defined, writes to addr <= PROT_ADDR_MAX while conv_en_i is high are
//   accepted but dropped, and the owning port gets a one-cycle err pulse.
//
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   m0, m1     : requester ports (reg_bus_arbiter_if.slave)
//   conv_en_i  : conversion-enable state from the register block
//   req        : register-block access strobe
//   wr_en      : register-block write enable
//   addr       : register-block address
//   wr_data    : register-block write data
//   rd_data    : register-block read data, combinational from addr

module reg_bus_arbiter #(
    parameter int         RR_INIT       = 0,
    parameter logic [7:0] PROT_ADDR_MAX = 8'd4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    reg_bus_arbiter_if.slave        m0,
    reg_bus_arbiter_if.slave        m1,
    input  logic                    conv_en_i,
    output logic                    req,
    output logic                    wr_en,
    output logic [7:0]              addr,
    output logic [7:0]              wr_data,
    input  logic [7:0]              rd_data
);

    localparam logic PRIO_RST = (RR_INIT != 0);

    logic       prio_q, prio_d;
    logic       req_q, req_d;
    logic       wr_en_q, wr_en_d;
    logic [7:0] addr_q, addr_d;
    logic [7:0] wr_data_q, wr_data_d;
    logic       own_q, own_d;
    logic       rd_pend_q, rd_pend_d;
    logic       rvalid0_q, rvalid0_d;
    logic       rvalid1_q, rvalid1_d;
    logic [7:0] rdata0_q, rdata0_d;
    logic [7:0] rdata1_q, rdata1_d;
    logic       err0_q, err0_d;
    logic       err1_q, err1_d;

    logic       grant0, grant1;
    logic       fire, sel, blocked;
    logic       cmd_wr;
    logic [7:0] cmd_addr, cmd_wdata;

    // prio_q names the port that wins when both are valid.
    assign grant0 = m0.valid & (~m1.valid | ~prio_q);
    assign grant1 = m1.valid & (~m0.valid |  prio_q);

    assign m0.ready = grant0;
    assign m1.ready = grant1;

    always_comb begin
        fire      = grant0 | grant1;
        sel       = grant1;
        cmd_wr    = sel ? m1.wr    : m0.wr;
        cmd_addr  = sel ? m1.addr  : m0.addr;
        cmd_wdata = sel ? m1.wdata : m0.wdata;

`ifdef REG_ARB_WR_PROTECT_EN
        blocked = fire & cmd_wr & conv_en_i & (cmd_addr <= PROT_ADDR_MAX);
`else
        blocked = 1'b0;
`endif

        prio_d    = fire ? ~sel : prio_q;
        req_d     = fire & ~blocked;
        wr_en_d   = fire & cmd_wr & ~blocked;
        // Address/data only move when something is actually issued, so an
        // idle bus (or a dropped protected write) keeps the last values.
        addr_d    = req_d ? cmd_addr  : addr_q;
        wr_data_d = req_d ? cmd_wdata : wr_data_q;
        own_d     = sel;
        rd_pend_d = fire & ~cmd_wr;
        err0_d    = blocked & ~sel;
        err1_d    = blocked &  sel;

        // rd_data reflects addr_q during the issue cycle; capture it at the
        // end of that cycle for the owning port only.
        rvalid0_d = rd_pend_q & ~own_q;
        rvalid1_d = rd_pend_q &  own_q;
        rdata0_d  = rvalid0_d ? rd_data : rdata0_q;
        rdata1_d  = rvalid1_d ? rd_data : rdata1_q;
    end

`ifndef REG_ARB_WR_PROTECT_EN
    logic [8:0] unused_cfg;
    assign unused_cfg = {conv_en_i, PROT_ADDR_MAX};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_q    <= PRIO_RST;
            req_q     <= 1'b0;
            wr_en_q   <= 1'b0;
            addr_q    <= 8'h00;
            wr_data_q <= 8'h00;
            own_q     <= 1'b0;
            rd_pend_q <= 1'b0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            rdata0_q  <= 8'h00;
            rdata1_q  <= 8'h00;
            err0_q    <= 1'b0;
            err1_q    <= 1'b0;
        end else begin
            prio_q    <= prio_d;
            req_q     <= req_d;
            wr_en_q   <= wr_en_d;
            addr_q    <= addr_d;
            wr_data_q <= wr_data_d;
            own_q     <= own_d;
            rd_pend_q <= rd_pend_d;
            rvalid0_q <= rvalid0_d;
            rvalid1_q <= rvalid1_d;
            rdata0_q  <= rdata0_d;
            rdata1_q  <= rdata1_d;
            err0_q    <= err0_d;
            err1_q    <= err1_d;
        end
    end

    assign req       = req_q;
    assign wr_en     = wr_en_q;
    assign addr      = addr_q;
    assign wr_data   = wr_data_q;
    assign m0.rvalid = rvalid0_q;
    assign m1.rvalid = rvalid1_q;
    assign m0.rdata  = rdata0_q;
    assign m1.rdata  = rdata1_q;
    assign m0.err    = err0_q;
    assign m1.err    = err1_q;

endmodule
